instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 13 +
 rtl/instruction_fetch_unit_program_counter.sv | 40 ++++
 rtl/instruction_fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } ifu_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned WORD_BYTES       = 4;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// rtl/instruction_fetch_unit_program_counter.sv - program counter register with next-pc mux
module program_counter
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_next;

    // Sequential increment wraps naturally at 2^32
    assign pc_plus4 = pc + 32'(WORD_BYTES);

    // Redirect beats advance; the target is forced word-aligned
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = {redirect_target[31:2], 2'b00};
        end else if (advance) begin
            pc_next = pc_plus4;
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: fsm, IF/ID register and fetch counter
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt,
    input  logic [31:0] imem_instruction,
    output logic [31:0] imem_address,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic [31:0] pc,
    output logic [31:0] fetch_count,
    output logic        misalign_err
);

    // Memory depth is informational only; fetch addressing uses the full PC
    if (IMEM_WORDS < 1) begin : g_imem_words_nonpositive
    end

    ifu_state_t  state_q, state_d;
    logic        do_fetch;
    logic        do_redirect;
    logic        do_clear;
    logic        do_invalidate;
    logic [31:0] pc_plus4;

    program_counter #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect       (do_redirect),
        .redirect_target(branch_target),
        .advance        (do_fetch),
        .pc             (pc),
        .pc_plus4       (pc_plus4)
    );

    assign imem_address = pc;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle actions; priority branch > flush > halt > stall
    always_comb begin
        state_d       = state_q;
        do_fetch      = 1'b0;
        do_redirect   = 1'b0;
        do_clear      = 1'b0;
        do_invalidate = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (branch_taken) begin
                    do_redirect = 1'b1;
                    do_clear    = 1'b1;
                end else if (flush) begin
                    do_clear = 1'b1;
                end else if (halt) begin
                    state_d       = HALTED;
                    do_invalidate = 1'b1;
                end else if (!stall) begin
                    do_fetch = 1'b1;
                end
            end
            HALTED: begin
                if (branch_taken) begin
                    do_redirect = 1'b1;
                    do_clear    = 1'b1;
                end else begin
                    do_clear = flush;
                    if (!halt) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // IF/ID register: squash, load, or drop only the valid bit on halt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instruction <= 32'h0;
            ifid_pc_plus4    <= 32'h0;
            ifid_valid       <= 1'b0;
        end else if (do_clear) begin
            ifid_instruction <= 32'h0;
            ifid_pc_plus4    <= 32'h0;
            ifid_valid       <= 1'b0;
        end else if (do_fetch) begin
            ifid_instruction <= imem_instruction;
            ifid_pc_plus4    <= pc_plus4;
            ifid_valid       <= 1'b1;
        end else if (do_invalidate) begin
            ifid_valid <= 1'b0;
        end
    end

    // Count of accepted fetches, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'h0;
        end else if (do_fetch) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    // Sticky record of any redirect to a non-word-aligned target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (do_redirect && (branch_target[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end

endmodule
